// File: rtl/sd_sector_responder_if.sv
// sd_sector_responder_if: sector handshake (core side) and toggle req/ack backing-store port
interface sd_sector_responder_if #(parameter int ST_AW = 15);
  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [7:0]       sd_buff_addr;
  logic [15:0]      sd_buff_dout;
  logic [15:0]      sd_buff_din;
  logic             sd_buff_wr;
  logic [ST_AW-1:0] st_addr;
  logic [15:0]      st_dout;
  logic [15:0]      st_din;
  logic             st_we;
  logic             st_req;
  logic             st_ack;
  logic             err;
  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, st_din, st_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, st_addr, st_dout, st_we, st_req, err
  );
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, st_din, st_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, st_addr, st_dout, st_we, st_req, err
  );
endinterface

// File: rtl/sd_sector_responder.sv
// sd_sector_responder: serves one 256-word sector per request from a toggle req/ack store
// Define SD_RESP_TIMEOUT_EN to add a store-ack watchdog that aborts stalled words and sets err.
module sd_sector_responder #(
  parameter int          SECTORS = 128,
  parameter int          ST_AW   = 15,
  parameter logic [15:0] FILL    = 16'hFFFF,
  parameter int          TIMEOUT = 4095
) (
  input  logic               MCLK,
  input  logic               RESET_N,
  sd_sector_responder_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_PUT, S_WR_ADDR, S_WR_CAP, S_WR_WAIT, S_DONE
  } state_t;
  if (ST_AW < $clog2(SECTORS) + 8 || TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_cfg
    $error("sd_sector_responder: ST_AW too narrow or TIMEOUT outside 1..4095");
  end
  state_t           r_state, w_next;
  logic [ST_AW-9:0] r_lba;
  logic [7:0]       r_idx;
  logic             r_ok, r_req, r_we;
  logic [15:0]      r_dout, r_st_dout;
  logic [ST_AW-1:0] r_st_addr;
  logic             w_acked, w_to, w_last, w_start;
  assign w_acked = bus.st_ack == r_req;
  assign w_last  = r_idx == 8'hFF;
  assign w_start = bus.sd_rd | bus.sd_wr;
`ifdef SD_RESP_TIMEOUT_EN
  logic [11:0] r_cnt;
  logic        r_err, w_wait;
  assign w_wait = (r_state == S_RD_WAIT || r_state == S_WR_WAIT) && !w_acked;
  assign w_to   = w_wait && r_cnt == 12'(TIMEOUT);
  always_ff @(posedge MCLK)
    if (!RESET_N) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (w_wait && !w_to) ? r_cnt + 12'd1 : '0;
      r_err <= r_err | w_to;
    end
  assign bus.err = r_err;
`else
  assign w_to    = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge MCLK)
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = !w_start ? S_IDLE : bus.sd_rd ? S_RD_REQ : S_WR_ADDR;
      S_RD_REQ:  w_next = r_ok ? S_RD_WAIT : S_RD_PUT;
      S_RD_WAIT: w_next = (w_acked || w_to) ? S_RD_PUT : S_RD_WAIT;
      S_RD_PUT:  w_next = w_last ? S_DONE : S_RD_REQ;
      S_WR_ADDR: w_next = S_WR_CAP;
      S_WR_CAP:  w_next = S_WR_WAIT;
      S_WR_WAIT: w_next = !(w_acked || w_to) ? S_WR_WAIT : w_last ? S_DONE : S_WR_ADDR;
      default:   w_next = S_IDLE;
    endcase
  end
  // An aborted word resyncs st_req to st_ack so the next toggle starts a clean access.
  always_ff @(posedge MCLK)
    if (!RESET_N) begin
      r_lba     <= '0;
      r_idx     <= '0;
      r_ok      <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_dout    <= '0;
      r_st_dout <= '0;
      r_st_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_lba <= bus.sd_lba[ST_AW-9:0];
          r_idx <= '0;
          r_ok  <= bus.sd_lba < 32'(SECTORS);
        end
        S_RD_REQ: if (r_ok) begin
          r_st_addr <= {r_lba, r_idx};
          r_we      <= 1'b0;
          r_req     <= ~r_req;
        end else r_dout <= FILL;
        S_RD_WAIT: if (w_acked) r_dout <= bus.st_din;
          else if (w_to) begin
            r_dout <= FILL;
            r_req  <= bus.st_ack;
          end
        S_RD_PUT: if (!w_last) r_idx <= r_idx + 8'd1;
        S_WR_CAP: if (r_ok) begin
          r_st_addr <= {r_lba, r_idx};
          r_st_dout <= bus.sd_buff_din;
          r_we      <= 1'b1;
          r_req     <= ~r_req;
        end
        S_WR_WAIT: begin
          if ((w_acked || w_to) && !w_last) r_idx <= r_idx + 8'd1;
          if (w_to) r_req <= bus.st_ack;
        end
        default: ;
      endcase
    end
  assign bus.sd_ack       = r_state != S_IDLE && r_state != S_DONE;
  assign bus.sd_buff_wr   = r_state == S_RD_PUT;
  assign bus.sd_buff_addr = r_idx;
  assign bus.sd_buff_dout = r_dout;
  assign bus.st_addr      = r_st_addr;
  assign bus.st_dout      = r_st_dout;
  assign bus.st_we        = r_we;
  assign bus.st_req       = r_req;
endmodule

// File: tb/tb_sd_sector_responder.sv
// tb_sd_sector_responder: directed sector reads/writes against a latency store model, scoreboarded
module tb_sd_sector_responder;
  typedef struct packed {logic [7:0] a; logic [15:0] d;} rd_t;
  typedef struct packed {logic [14:0] a; logic [15:0] d;} wr_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] mem [0:32767];
  logic [15:0] bram [0:255];
  rd_t         rq[$], re;
  wr_t         wq[$], we_e;
  int          tests = 0, fails = 0, strobes = 0, toggles = 0, lat = 0;
  logic        exp_we = 1'b0, prev_req = 1'b0, stall_en = 1'b0, loaded = 1'b0;
  logic [14:0] stall_addr = '0;
  always #5 clk = ~clk;
  sd_sector_responder_if #(.ST_AW(15)) bus ();
  sd_sector_responder #(.SECTORS(128), .ST_AW(15), .FILL(16'hFFFF), .TIMEOUT(16)) dut (
    .MCLK(clk), .RESET_N(rst_n), .bus(bus)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  // Store model: acks each toggle after 3 cycles unless the stalled address is pending.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
      loaded <= 1'b1;
    end
    if (!rst_n) begin
      bus.st_ack <= 1'b0;
      lat        <= 0;
    end else if (bus.st_req != bus.st_ack && !(stall_en && bus.st_addr == stall_addr)) begin
      if (lat == 2) begin
        if (bus.st_we) mem[bus.st_addr] <= bus.st_dout;
        else           bus.st_din       <= mem[bus.st_addr];
        bus.st_ack <= bus.st_req;
        lat        <= 0;
      end else lat <= lat + 1;
    end
  end
  always @(posedge clk) bus.sd_buff_din <= bram[bus.sd_buff_addr];
  always @(negedge clk) begin
    if (bus.sd_buff_wr === 1'b1) begin
      strobes++;
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_strobe: got addr %0d, expected no strobe", bus.sd_buff_addr);
      end else begin
        re = rq.pop_front();
        chk("rd_addr", 32'(bus.sd_buff_addr), 32'(re.a));
        chk("rd_data", 32'(bus.sd_buff_dout), 32'(re.d));
      end
    end
    if (bus.st_req !== prev_req) begin
      toggles++;
      chk("st_we", 32'(bus.st_we), 32'(exp_we));
      if (bus.st_we === 1'b1) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_store_write: got addr %h, expected none", bus.st_addr);
        end else begin
          we_e = wq.pop_front();
          chk("st_addr", 32'(bus.st_addr), 32'(we_e.a));
          chk("st_dout", 32'(bus.st_dout), 32'(we_e.d));
        end
      end
    end
    prev_req = bus.st_req;
  end
  task automatic push_rd(input logic [7:0] lba, input bit fill, input int bad);
    for (int a = 0; a < 256; a++)
      rq.push_back('{a: 8'(a), d: (fill || a == bad) ? 16'hFFFF : {lba, 8'(a)} ^ 16'h5A5A});
  endtask
  task automatic req(input logic rd, input logic wr, input logic [31:0] lba);
    strobes = 0;
    toggles = 0;
    @(posedge clk); #1;
    chk("ack_idle", 32'(bus.sd_ack), 32'd0);
    bus.sd_lba = lba; bus.sd_rd = rd; bus.sd_wr = wr;
    @(posedge clk); #1;
    chk("ack_rise", 32'(bus.sd_ack), 32'd1);
    bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.sd_ack === 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_fall", 32'(bus.sd_ack), 32'd0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 256; i++) bram[i] = 16'h1000 + 16'(i);
    bus.sd_lba = '0; bus.sd_rd = 1'b0; bus.sd_wr = 1'b0; bus.st_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.sd_ack), 32'd0);
    chk("rst_buff_wr", 32'(bus.sd_buff_wr), 32'd0);
    chk("rst_st_req", 32'(bus.st_req), 32'd0);
    chk("rst_st_we", 32'(bus.st_we), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_buff_addr", 32'(bus.sd_buff_addr), 32'd0);
    chk("rst_buff_dout", 32'(bus.sd_buff_dout), 32'd0);
    chk("rst_st_addr", 32'(bus.st_addr), 32'd0);
    chk("rst_st_dout", 32'(bus.st_dout), 32'd0);
    rst_n = 1'b1;
    exp_we = 1'b0;
    push_rd(8'd3, 1'b0, -1);
    req(1'b1, 1'b0, 32'd3);
    wait_done();
    chk("rd3_left", 32'(rq.size()), 32'd0);
    chk("rd3_strobes", 32'(strobes), 32'd256);
    chk("rd3_toggles", 32'(toggles), 32'd256);
    exp_we = 1'b1;
    for (int i = 0; i < 256; i++) wq.push_back('{a: 15'h7F00 + 15'(i), d: 16'h1000 + 16'(i)});
    req(1'b0, 1'b1, 32'd127);
    wait_done();
    chk("wr127_left", 32'(wq.size()), 32'd0);
    chk("wr127_toggles", 32'(toggles), 32'd256);
    chk("wr127_strobes", 32'(strobes), 32'd0);
    for (int i = 0; i < 256; i++) chk("wr127_mem", 32'(mem[15'h7F00 + 15'(i)]), 32'h1000 + 32'(i));
    exp_we = 1'b0;
    push_rd(8'd200, 1'b1, -1);
    req(1'b1, 1'b0, 32'd200);
    wait_done();
    chk("oor_rd_left", 32'(rq.size()), 32'd0);
    chk("oor_rd_strobes", 32'(strobes), 32'd256);
    chk("oor_rd_toggles", 32'(toggles), 32'd0);
    exp_we = 1'b1;
    req(1'b0, 1'b1, 32'd200);
    wait_done();
    chk("oor_wr_toggles", 32'(toggles), 32'd0);
    chk("oor_wr_strobes", 32'(strobes), 32'd0);
    chk("oor_wr_mem0", 32'(mem[15'h4800]), 32'h4800 ^ 32'h5A5A);
    chk("oor_wr_mem255", 32'(mem[15'h48FF]), 32'h48FF ^ 32'h5A5A);
    exp_we = 1'b0;
    push_rd(8'd0, 1'b0, -1);
    req(1'b1, 1'b1, 32'd0);
    wait_done();
    chk("both_left", 32'(rq.size()), 32'd0);
    chk("both_strobes", 32'(strobes), 32'd256);
    chk("both_toggles", 32'(toggles), 32'd256);
    chk("both_mem", 32'(mem[15'h00FF]), 32'h00FF ^ 32'h5A5A);
    push_rd(8'd2, 1'b0, -1);
    req(1'b1, 1'b0, 32'd2);
    n = 0;
    while (!(bus.sd_buff_wr === 1'b1 && bus.sd_buff_addr == 8'd100) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reach_word100", 32'(bus.sd_buff_addr), 32'd100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", 32'(bus.sd_ack), 32'd0);
    chk("mid_rst_buff_wr", 32'(bus.sd_buff_wr), 32'd0);
    chk("mid_rst_strobes", 32'(strobes), 32'd101);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rq.delete();
    push_rd(8'd1, 1'b0, -1);
    req(1'b1, 1'b0, 32'd1);
    wait_done();
    chk("post_rst_left", 32'(rq.size()), 32'd0);
    chk("post_rst_strobes", 32'(strobes), 32'd256);
    chk("post_rst_toggles", 32'(toggles), 32'd256);
    stall_addr = 15'h0405;
    stall_en = 1'b1;
`ifdef SD_RESP_TIMEOUT_EN
    push_rd(8'd4, 1'b0, 5);
    req(1'b1, 1'b0, 32'd4);
    wait_done();
    chk("stall_err", 32'(bus.err), 32'd1);
`else
    push_rd(8'd4, 1'b0, -1);
    req(1'b1, 1'b0, 32'd4);
    n = 0;
    while (strobes < 5 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (100) @(posedge clk);
    #1;
    chk("stall_ack_held", 32'(bus.sd_ack), 32'd1);
    chk("stall_strobes", 32'(strobes), 32'd5);
    chk("stall_err", 32'(bus.err), 32'd0);
    stall_en = 1'b0;
    wait_done();
`endif
    stall_en = 1'b0;
    chk("stall_left", 32'(rq.size()), 32'd0);
    chk("stall_total_strobes", 32'(strobes), 32'd256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
